// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the I-cache and D-cache fill paths.
// Each access is held on the port for LATENCY cycles; the winning side then gets a one-cycle done pulse.
module mem_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 6
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_done,
  output logic [WORD_SIZE*LINE_WORDS-1:0] i_rdata,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
  output logic                            d_done,
  output logic [WORD_SIZE*LINE_WORDS-1:0] d_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata
);

  localparam int LINE_BITS = WORD_SIZE * LINE_WORDS;
  localparam int CNT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_BITS-1:0]  CNT_START  = CNT_BITS'(LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arbState_t;

  arbState_t           state;
  logic [CNT_BITS-1:0] cnt;
  logic                ownerD;
  logic                writeOp;

  // Strobes, address and write data are registered at grant so they sit
  // high for exactly the LATENCY cycles spent in BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ownerD    <= 1'b0;
      writeOp   <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state)
        IDLE: begin
          // D wins ties: it carries the older instruction in the pipeline.
          if (d_req) begin
            ownerD    <= 1'b1;
            writeOp   <= d_we;
            mem_addr  <= d_addr & ALIGN_MASK;
            mem_wdata <= d_wdata;
            mem_read  <= ~d_we;
            mem_write <= d_we;
            cnt       <= CNT_START;
            state     <= BUSY;
          end else if (i_req) begin
            ownerD    <= 1'b0;
            writeOp   <= 1'b0;
            mem_addr  <= i_addr & ALIGN_MASK;
            mem_wdata <= d_wdata;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            cnt       <= CNT_START;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!writeOp) begin
              if (ownerD) d_rdata <= mem_rdata[LINE_BITS-1:0];
              else        i_rdata <= mem_rdata[LINE_BITS-1:0];
            end
            i_done <= ~ownerD;
            d_done <= ownerD;
            state  <= DONE;
          end
        end
        DONE: begin
          // The requester drops req on this edge, so no grant is made here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected done pulses and
// memory transfers; independent monitors pop and compare them as the DUT produces them.
module tb_mem_arbiter;

  localparam int WS  = 16;
  localparam int LW  = 4;
  localparam int LAT = 6;
  localparam int LB  = WS * LW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_we;
  logic [WS-1:0] i_addr, d_addr;
  logic [LB-1:0] d_wdata;
  logic          i_done, d_done;
  logic [LB-1:0] i_rdata, d_rdata;
  logic          mem_read, mem_write;
  logic [WS-1:0] mem_addr;
  logic [LB-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.WORD_SIZE(WS), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            isD;
    logic [LB-1:0] rdata;
    int            cyc;
  } doneExp_t;

  typedef struct {
    bit            wr;
    logic [WS-1:0] addr;
    logic [LB-1:0] wdata;
    int            len;
  } memExp_t;

  doneExp_t doneQ[$];
  memExp_t  memQ[$];
  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checkCount++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    else passCount++;
  endtask

  // Memory model: line data is only valid in the final cycle of a read burst.
  int readRun;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) readRun <= 0;
    else          readRun <= mem_read ? readRun + 1 : 0;
  end

  function automatic logic [LB-1:0] memLookup(input logic [WS-1:0] a);
    case (a)
      16'h0010: return 64'h0004_0003_0002_0001;
      16'h0104: return 64'h1111_2222_3333_4444;
      16'h0200: return 64'h0A0B_0C0D_0E0F_1011;
      16'h0030: return 64'h5555_6666_7777_8888;
      16'h0054: return 64'h9999_AAAA_BBBB_CCCC;
      16'h0074: return 64'h0123_4567_89AB_CDEF;
      default:  return 64'hFFFF_0000_FFFF_0000;
    endcase
  endfunction

  always_comb begin
    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    if (mem_read && readRun == LAT - 1) mem_rdata = memLookup(mem_addr);
  end

  // Done monitor
  always @(negedge clk) begin
    if (reset_n && (i_done || d_done)) begin
      check("done_exclusive", {63'd0, i_done && d_done}, '0);
      if (doneQ.size() == 0) begin
        check("unexpected_done", {62'd0, d_done, i_done}, '0);
      end else begin
        doneExp_t e;
        e = doneQ.pop_front();
        $display("done side=%s cycle=%0d rdata=%h", d_done ? "D" : "I", cycle, d_done ? d_rdata : i_rdata);
        check("done_side", {63'd0, d_done}, {63'd0, e.isD});
        check("done_cycle", LB'(cycle), LB'(e.cyc));
        check(e.isD ? "d_rdata" : "i_rdata", e.isD ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  // Memory port monitor: one comparison set per strobe burst
  bit            inRun = 0;
  int            runLen;
  bit            runWr;
  logic [WS-1:0] runAddr;
  logic [LB-1:0] runWdata;

  always @(negedge clk) begin
    if (!reset_n) begin
      inRun = 0;
    end else if (mem_read || mem_write) begin
      if (!inRun) begin
        check("strobe_exclusive", {63'd0, mem_read && mem_write}, '0);
        inRun = 1; runLen = 0; runWr = mem_write; runAddr = mem_addr; runWdata = mem_wdata;
      end
      runLen++;
    end else if (inRun) begin
      inRun = 0;
      $display("mem %s addr=%h len=%0d", runWr ? "write" : "read", runAddr, runLen);
      if (memQ.size() == 0) begin
        check("unexpected_mem_access", LB'(runLen), '0);
      end else begin
        memExp_t m;
        m = memQ.pop_front();
        check("mem_dir", {63'd0, runWr}, {63'd0, m.wr});
        check("mem_addr", LB'(runAddr), LB'(m.addr));
        check("mem_len", LB'(runLen), LB'(m.len));
        if (m.wr) check("mem_wdata", runWdata, m.wdata);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Acts as both requesters: each drops its req on the edge where it sees done.
  task automatic runUntilIdle(input int maxCycles);
    bit seenI, seenD;
    int n = 0;
    while ((i_req || d_req) && n < maxCycles) begin
      @(negedge clk);
      seenI = i_done;
      seenD = d_done;
      @(posedge clk);
      #1;
      if (seenI) i_req = 0;
      if (seenD) d_req = 0;
      n++;
    end
    check("reqs_released", {62'd0, i_req, d_req}, '0);
    i_req = 0;
    d_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, strobeCycles;
    reset_n = 0; i_req = 1; d_req = 1; d_we = 0;
    i_addr = 16'h0013; d_addr = 16'h0042; d_wdata = '0;

    // Reset with requests held high
    repeat (2) @(negedge clk);
    check("rst_done", {62'd0, i_done, d_done}, '0);
    check("rst_strobes", {62'd0, mem_read, mem_write}, '0);
    check("rst_mem_addr", LB'(mem_addr), '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    @(posedge clk); #1;
    i_req = 0; d_req = 0; reset_n = 1;
    strobeCycles = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_read || mem_write) strobeCycles++;
    end
    check("idle_strobes", LB'(strobeCycles), '0);
    @(posedge clk); #1;

    // I read
    start = cycle;
    doneQ.push_back('{0, 64'h0004_0003_0002_0001, start + 7});
    memQ.push_back('{0, 16'h0010, '0, 6});
    i_addr = 16'h0013; i_req = 1;
    runUntilIdle(40);

    // Simultaneous: D read first, I granted in the following IDLE cycle
    start = cycle;
    doneQ.push_back('{1, 64'h1111_2222_3333_4444, start + 7});
    doneQ.push_back('{0, 64'h0A0B_0C0D_0E0F_1011, start + 15});
    memQ.push_back('{0, 16'h0104, '0, 6});
    memQ.push_back('{0, 16'h0200, '0, 6});
    d_addr = 16'h0105; d_we = 0; i_addr = 16'h0200;
    d_req = 1; i_req = 1;
    runUntilIdle(40);

    // D write leaves d_rdata holding the previous read line
    start = cycle;
    doneQ.push_back('{1, 64'h1111_2222_3333_4444, start + 7});
    memQ.push_back('{1, 16'h0040, 64'hDEAD_BEEF_CAFE_F00D, 6});
    d_addr = 16'h0042; d_we = 1; d_wdata = 64'hDEAD_BEEF_CAFE_F00D; d_req = 1;
    runUntilIdle(40);
    d_we = 0; d_wdata = '0;

    // D request arrives while I is busy
    start = cycle;
    doneQ.push_back('{0, 64'h5555_6666_7777_8888, start + 7});
    doneQ.push_back('{1, 64'h9999_AAAA_BBBB_CCCC, start + 15});
    memQ.push_back('{0, 16'h0030, '0, 6});
    memQ.push_back('{0, 16'h0054, '0, 6});
    i_addr = 16'h0031; i_req = 1;
    tick(3);
    d_addr = 16'h0057; d_req = 1;
    runUntilIdle(40);

    // Reset in the 3rd BUSY cycle, then re-grant of the held i_req
    i_addr = 16'h0077; i_req = 1;
    tick(3);
    reset_n = 0;
    #1;
    check("midrst_strobes", {62'd0, mem_read, mem_write}, '0);
    check("midrst_mem_addr", LB'(mem_addr), '0);
    check("midrst_i_rdata", i_rdata, '0);
    check("midrst_d_rdata", d_rdata, '0);
    @(negedge clk);
    check("midrst_no_done", {62'd0, i_done, d_done}, '0);
    tick(2);
    reset_n = 1;
    start = cycle;
    doneQ.push_back('{0, 64'h0123_4567_89AB_CDEF, start + 7});
    memQ.push_back('{0, 16'h0074, '0, 6});
    runUntilIdle(40);

    tick(4);
    check("done_queue_empty", LB'(doneQ.size()), '0);
    check("mem_queue_empty", LB'(memQ.size()), '0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
